// File: rtl/sad_pkg.sv
// Shared types and constants for the SAD motion-search datapath.
package sad_pkg;
    localparam int SAD_W = 32;
    localparam logic [SAD_W-1:0] SAD_MAX = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_t;
endpackage

// File: rtl/sad_sat_add.sv
// Combinational unsigned adder clamped to SAD_MAX instead of wrapping.
module sad_sat_add
    import sad_pkg::*;
(
    input  logic [SAD_W-1:0] a,
    input  logic [SAD_W-1:0] b,
    output logic [SAD_W-1:0] sum
);
    logic [SAD_W:0] full;

    assign full = {1'b0, a} + {1'b0, b};
    assign sum  = full[SAD_W] ? SAD_MAX : full[SAD_W-1:0];
endmodule

// File: rtl/sad_min_tracker.sv
// Sums BLOCK_LEN absolute differences per candidate and tracks the minimum
// candidate SAD and its index over NUM_CAND candidates.
module sad_min_tracker
    import sad_pkg::*;
#(
    parameter int BLOCK_LEN = 16,
    parameter int NUM_CAND  = 64,
    parameter int IDX_W     = 16
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Start,
    input  logic [SAD_W-1:0]  DiffIn,
    input  logic              DiffValid,
    output logic              DiffReady,
    output logic [SAD_W-1:0]  CandSAD,
    output logic              CandValid,
    output logic [SAD_W-1:0]  BestSAD,
    output logic [IDX_W-1:0]  BestIdx,
    output logic              Done
);
    localparam int CNT_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
    localparam int CID_W = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1;

    state_t             state, state_nxt;
    logic [SAD_W-1:0]   acc, acc_sum;
    logic [CNT_W-1:0]   ecnt;
    logic [CID_W-1:0]   cidx;
    logic               xfer, last_elem, last_cand, better;

    sad_sat_add u_add (
        .a   (acc),
        .b   (DiffIn),
        .sum (acc_sum)
    );

    assign xfer      = DiffValid && DiffReady;
    assign last_elem = (ecnt == CNT_W'(BLOCK_LEN - 1));
    assign last_cand = (cidx == CID_W'(NUM_CAND - 1));
    // Strict compare: a tie keeps the earlier candidate.
    assign better    = (acc < BestSAD);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (Start) begin
            state_nxt = ACCUM;
        end else begin
            case (state)
                ACCUM:   if (xfer && last_elem) state_nxt = COMPARE;
                COMPARE: state_nxt = last_cand ? DONE : ACCUM;
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        DiffReady = (state == ACCUM);
        Done      = (state == DONE);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            acc       <= '0;
            ecnt      <= '0;
            cidx      <= '0;
            CandSAD   <= '0;
            CandValid <= 1'b0;
            BestSAD   <= SAD_MAX;
            BestIdx   <= '0;
        end else if (Start) begin
            acc       <= '0;
            ecnt      <= '0;
            cidx      <= '0;
            CandValid <= 1'b0;
            BestSAD   <= SAD_MAX;
            BestIdx   <= '0;
        end else begin
            CandValid <= 1'b0;
            case (state)
                ACCUM: begin
                    if (xfer) begin
                        acc  <= acc_sum;
                        ecnt <= ecnt + 1'b1;
                    end
                end
                COMPARE: begin
                    CandSAD   <= acc;
                    CandValid <= 1'b1;
                    if (better) begin
                        BestSAD <= acc;
                        BestIdx <= IDX_W'(cidx);
                    end
                    acc  <= '0;
                    ecnt <= '0;
                    if (!last_cand) cidx <= cidx + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sad_min_tracker.sv
// Bench for sad_min_tracker: vector table of full searches with a candidate
// SAD scoreboard, plus hand-written idle, abort and mid-search reset sequences.
module tb_sad_min_tracker;
    import sad_pkg::*;

    localparam int BL = 4;
    localparam int NC = 3;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Start = 1'b0;
    logic [31:0] DiffIn = '0;
    logic        DiffValid = 1'b0;
    logic        DiffReady;
    logic [31:0] CandSAD;
    logic        CandValid;
    logic [31:0] BestSAD;
    logic [15:0] BestIdx;
    logic        Done;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    logic [31:0] expq[$];

    // d lists 12 diffs in natural order (element i is d[11-i]); sad likewise (sad[2-c]).
    typedef struct packed {
        logic              stall;
        logic [11:0][31:0] d;
        logic [2:0][31:0]  sad;
        logic [31:0]       best;
        logic [15:0]       idx;
        logic              timed;
    } vec_t;

    vec_t vt[5];

    sad_min_tracker #(.BLOCK_LEN(BL), .NUM_CAND(NC), .IDX_W(16)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Start     (Start),
        .DiffIn    (DiffIn),
        .DiffValid (DiffValid),
        .DiffReady (DiffReady),
        .CandSAD   (CandSAD),
        .CandValid (CandValid),
        .BestSAD   (BestSAD),
        .BestIdx   (BestIdx),
        .Done      (Done)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge Clk) begin
        if (Rst_n && CandValid) begin
            if (expq.size() == 0) begin
                total++;
                $display("FAIL cand_unexpected: got pulse with CandSAD %h expected no pulse", CandSAD);
            end else begin
                chk("cand_sad", CandSAD, expq.pop_front());
            end
        end
    end

    task automatic pulse_start();
        @(posedge Clk); #1;
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        chk("start_ready", {31'd0, DiffReady}, 32'd1);
        chk("start_done", {31'd0, Done}, 32'd0);
        chk("start_best", BestSAD, SAD_MAX);
        chk("start_idx", {16'd0, BestIdx}, 32'd0);
    endtask

    // Entered and left just after a rising edge; one transfer per call.
    task automatic send(input logic [31:0] d, input logic stall);
        int n = 0;
        if (stall) begin
            DiffValid = 1'b0;
            @(posedge Clk); #1;
        end
        DiffValid = 1'b1;
        DiffIn    = d;
        @(negedge Clk);
        while (!DiffReady && n < 20) begin
            @(negedge Clk);
            n++;
        end
        if (!DiffReady) chk("ready_timeout", {31'd0, DiffReady}, 32'd1);
        @(posedge Clk); #1;
        DiffValid = 1'b0;
    endtask

    task automatic wait_done(output int at);
        int n = 0;
        @(negedge Clk);
        while (!Done && n < 60) begin
            @(negedge Clk);
            n++;
        end
        chk("done_seen", {31'd0, Done}, 32'd1);
        at = cyc;
    endtask

    task automatic run_vec(input vec_t v, input bit skip_start);
        int c1 = 0;
        int cd;
        if (!skip_start) pulse_start();
        for (int i = 0; i < 12; i++) begin
            if (i % 4 == 3) expq.push_back(v.sad[2 - i / 4]);
            send(v.d[11 - i], v.stall);
            if (i == 0) c1 = cyc;
        end
        wait_done(cd);
        if (v.timed) chk("done_latency", 32'(cd - c1), 32'd14);
        chk("best_sad", BestSAD, v.best);
        chk("best_idx", {16'd0, BestIdx}, {16'd0, v.idx});
        chk("done_ready", {31'd0, DiffReady}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        vt[0] = '{1'b0, {32'd1, 32'd2, 32'd3, 32'd4, 32'd0, 32'd0, 32'd0, 32'd1, 32'd2, 32'd2, 32'd2, 32'd2},
                  {32'd10, 32'd1, 32'd8}, 32'd1, 16'd1, 1'b1};
        vt[1] = '{1'b0, {32'd1, 32'd2, 32'd3, 32'd1, 32'd7, 32'd0, 32'd0, 32'd0, 32'd2, 32'd3, 32'd4, 32'd0},
                  {32'd7, 32'd7, 32'd9}, 32'd7, 16'd0, 1'b0};
        vt[2] = '{1'b0, {32'hFFFFFFF0, 32'h20, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd1,
                         32'd5, 32'd5, 32'd5, 32'd5},
                  {32'hFFFFFFFF, 32'hFFFFFFFF, 32'd20}, 32'd20, 16'd2, 1'b0};
        vt[3] = '{1'b1, {32'd1, 32'd2, 32'd3, 32'd4, 32'd0, 32'd0, 32'd0, 32'd1, 32'd2, 32'd2, 32'd2, 32'd2},
                  {32'd10, 32'd1, 32'd8}, 32'd1, 16'd1, 1'b0};
        vt[4] = '{1'b0, {12{32'hFFFFFFFF}},
                  {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF}, 32'hFFFFFFFF, 16'd0, 1'b0};

        // Reset values, then idle with DiffValid asserted.
        #12;
        chk("rst_ready", {31'd0, DiffReady}, 32'd0);
        chk("rst_cvalid", {31'd0, CandValid}, 32'd0);
        chk("rst_done", {31'd0, Done}, 32'd0);
        chk("rst_cand", CandSAD, 32'd0);
        chk("rst_best", BestSAD, SAD_MAX);
        chk("rst_idx", {16'd0, BestIdx}, 32'd0);
        @(posedge Clk); #1;
        Rst_n     = 1'b1;
        DiffValid = 1'b1;
        DiffIn    = 32'd5;
        repeat (4) begin
            @(negedge Clk);
            chk("idle_ready", {31'd0, DiffReady}, 32'd0);
        end
        chk("idle_best", BestSAD, SAD_MAX);
        DiffValid = 1'b0;

        for (int v = 0; v < 5; v++) run_vec(vt[v], 1'b0);

        // Abort mid-candidate 1; the following diffs must count from candidate 0.
        pulse_start();
        expq.push_back(32'd4);
        for (int i = 0; i < 4; i++) send(32'd1, 1'b0);
        send(32'd1, 1'b0);
        send(32'd1, 1'b0);
        chk("pre_abort_best", BestSAD, 32'd4);
        pulse_start();
        run_vec('{1'b0, {32'd3, 32'd3, 32'd3, 32'd3, 32'd9, 32'd9, 32'd9, 32'd9, 32'd1, 32'd0, 32'd0, 32'd0},
                  {32'd12, 32'd36, 32'd1}, 32'd1, 16'd2, 1'b0}, 1'b1);

        // Asynchronous reset in the middle of ACCUM.
        pulse_start();
        expq.push_back(32'd8);
        for (int i = 0; i < 4; i++) send(32'd2, 1'b0);
        send(32'd5, 1'b0);
        send(32'd6, 1'b0);
        chk("pre_rst_best", BestSAD, 32'd8);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", {31'd0, DiffReady}, 32'd0);
        chk("mid_rst_cand", CandSAD, 32'd0);
        chk("mid_rst_best", BestSAD, SAD_MAX);
        chk("mid_rst_idx", {16'd0, BestIdx}, 32'd0);
        chk("mid_rst_done", {31'd0, Done}, 32'd0);
        chk("mid_rst_cvalid", {31'd0, CandValid}, 32'd0);
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        chk("post_rst_ready", {31'd0, DiffReady}, 32'd0);
        chk("queue_empty", 32'(expq.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
